// File: rtl/iso14443_2a_fdt_scheduler.sv
// rtl/iso14443_2a_fdt_scheduler.sv - holds PICC Tx off until an ISO/IEC 14443-3 FDT grid slot, then passes the frame through
module iso14443_2a_fdt_scheduler #(
  parameter int MIN_N        = 9,
  parameter int MAX_N        = 16,
  parameter int LATENCY_COMP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n_synchronised,
  input  logic rx_eoc,
  input  logic rx_error,
  input  logic rx_last_bit,
  input  logic up_tx_req,
  input  logic up_tx_data,
  input  logic up_tx_last,
  output logic up_tx_ready,
  output logic tx_req,
  output logic tx_data,
  output logic tx_last,
  input  logic tx_ready,
  output logic fdt_timeout,
  output logic sched_active
);

  localparam int              SW       = $clog2(MAX_N + 1);
  localparam logic [SW-1:0]   SLOT_MIN = SW'(MIN_N);
  localparam logic [SW-1:0]   SLOT_MAX = SW'(MAX_N);
  localparam logic [6:0]      COMP     = 7'(LATENCY_COMP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            pause_prev;
  logic [6:0]      fine;
  logic [SW-1:0]   slot;
  logic [6:0]      offset;
  logic [6:0]      trig;
  logic            pause_rise;
  logic            pause_fall;
  logic            slot_hit;

  assign pause_rise   = pause_n_synchronised & ~pause_prev;
  assign pause_fall   = ~pause_n_synchronised & pause_prev;
  assign trig         = offset - COMP;
  assign slot_hit     = (fine == trig) && (slot >= SLOT_MIN) && (state == COUNTING);
  assign sched_active = (state == COUNTING) || (state == SEND);

  // Remember the previous pause level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_prev <= 1'b1;
    else        pause_prev <= pause_n_synchronised;
  end

  // Free-running fine/slot time base, restarted at the end of each pause while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine <= '0;
      slot <= '0;
    end else if (state == IDLE && pause_rise) begin
      fine <= '0;
      slot <= '0;
    end else begin
      fine <= fine + 7'd1;
      if (fine == 7'd127 && slot != SLOT_MAX) slot <= slot + 1'b1;
    end
  end

  // Latch the FDT offset chosen by the last received data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         offset <= 7'd84;
    else if (rx_eoc && state != SEND)   offset <= rx_last_bit ? 7'd84 : 7'd20;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and gated Tx passthrough; the first bit is offered combinationally on the slot.
  always_comb begin
    state_nxt   = state;
    tx_req      = 1'b0;
    tx_data     = 1'b0;
    tx_last     = 1'b0;
    up_tx_ready = 1'b0;
    fdt_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rx_eoc && !rx_error) state_nxt = COUNTING;
      end
      COUNTING: begin
        if (pause_fall) begin
          state_nxt = IDLE;
        end else if (slot_hit) begin
          if (up_tx_req) begin
            tx_req      = 1'b1;
            tx_data     = up_tx_data;
            tx_last     = up_tx_last;
            up_tx_ready = tx_ready;
            // A single-bit frame accepted right on the slot is already complete.
            state_nxt   = (tx_ready && up_tx_last) ? IDLE : SEND;
          end else if (slot == SLOT_MAX) begin
            fdt_timeout = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      SEND: begin
        tx_req      = up_tx_req;
        tx_data     = up_tx_data;
        tx_last     = up_tx_last;
        up_tx_ready = tx_ready;
        if (up_tx_req && tx_ready && up_tx_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iso14443_2a_fdt_scheduler.sv
// tb/tb_iso14443_2a_fdt_scheduler.sv - scoreboard bench for the FDT scheduler
module tb_iso14443_2a_fdt_scheduler;

  localparam int MIN_N = 9;
  localparam int MAX_N = 16;
  localparam int LC    = 3;

  localparam int K_OFFER = 0;
  localparam int K_BIT   = 1;
  localparam int K_TMO   = 2;

  typedef struct {
    int     kind;
    longint cyc;
    bit     data;
    bit     last;
  } ev_t;

  logic clk;
  logic rst_n;
  logic pause_n_synchronised;
  logic rx_eoc;
  logic rx_error;
  logic rx_last_bit;
  logic up_tx_req;
  logic up_tx_data;
  logic up_tx_last;
  logic up_tx_ready;
  logic tx_req;
  logic tx_data;
  logic tx_last;
  logic tx_ready;
  logic fdt_timeout;
  logic sched_active;

  ev_t    sb[$];
  int     checks;
  int     failures;
  int     viol;
  int     txreq_cnt;
  longint cyc;
  bit     ready_en;
  bit     fb[128];
  int     fn;

  iso14443_2a_fdt_scheduler #(
    .MIN_N(MIN_N), .MAX_N(MAX_N), .LATENCY_COMP(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pause_n_synchronised(pause_n_synchronised),
    .rx_eoc(rx_eoc),
    .rx_error(rx_error),
    .rx_last_bit(rx_last_bit),
    .up_tx_req(up_tx_req),
    .up_tx_data(up_tx_data),
    .up_tx_last(up_tx_last),
    .up_tx_ready(up_tx_ready),
    .tx_req(tx_req),
    .tx_data(tx_data),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .fdt_timeout(fdt_timeout),
    .sched_active(sched_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Emulated iso14443_2a tx_iface: random backpressure.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_en ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input bit d, input bit l);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got event kind=%0d data=%0d last=%0d at cycle %0d, expected no event", kind, d, l, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (e.cyc >= 0 && e.cyc != cyc) ||
          (kind == K_BIT && (e.data != d || e.last != l))) begin
        failures++;
        $display("FAIL sb_event: got kind=%0d cycle=%0d data=%0d last=%0d, expected kind=%0d cycle=%0d data=%0d last=%0d",
                 kind, cyc, d, l, e.kind, e.cyc, e.data, e.last);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an offer, a bit handshake or a timeout.
  initial begin
    bit prev_req;
    prev_req = 1'b0;
    viol = 0;
    txreq_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (tx_req) txreq_cnt++;
        if (tx_req && !prev_req)  expect_ev(K_OFFER, 1'b0, 1'b0);
        if (tx_req && tx_ready)   expect_ev(K_BIT, tx_data, tx_last);
        if (fdt_timeout)          expect_ev(K_TMO, 1'b0, 1'b0);
        if (!tx_req && (tx_data || tx_last || up_tx_ready)) viol++;
        if ((tx_req || fdt_timeout) && !sched_active) viol++;
        prev_req = tx_req;
      end
    end
  end

  // Reference model: first grid slot n >= MIN_N at or after the request, else timeout at MAX_N.
  task automatic model(input longint r, input bit lb, input longint q, output bit tmo, output longint t);
    longint off;
    off = lb ? 84 : 20;
    tmo = 1'b1;
    t = r + longint'(MAX_N) * 128 + off - LC;
    for (int n = MIN_N; n <= MAX_N; n++) begin
      if (tmo && (r + longint'(n) * 128 + off - LC) >= q) begin
        tmo = 1'b0;
        t = r + longint'(n) * 128 + off - LC;
      end
    end
  endtask

  task automatic push(input int kind, input longint c, input bit d, input bit l);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fill_frame(input int n);
    fn = n;
    for (int i = 0; i < n; i++) fb[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame(input longint t);
    push(K_OFFER, t, 1'b0, 1'b0);
    for (int i = 0; i < fn; i++) push(K_BIT, -1, fb[i], (i == fn - 1));
  endtask

  task automatic present_first();
    up_tx_req = 1'b1;
    up_tx_data = fb[0];
    up_tx_last = (fn == 1);
  endtask

  // Returns r = cycle of the edge that registers the end of the last pause.
  task automatic pause_seq(input int npause, output longint r);
    r = 0;
    for (int i = 0; i < npause; i++) begin
      pause_n_synchronised = 1'b0;
      idle($urandom_range(4, 30));
      pause_n_synchronised = 1'b1;
      r = cyc + 1;
      idle($urandom_range(20, 80));
    end
  endtask

  task automatic eoc(input bit lb, input bit err);
    rx_eoc = 1'b1;
    rx_last_bit = lb;
    rx_error = err;
    tick();
    rx_eoc = 1'b0;
    rx_error = 1'b0;
  endtask

  // Upstream bit source: raises the request at cycle q and walks the frame on each handshake.
  task automatic send_frame(input longint q);
    int idx;
    int guard;
    bit hs;
    while (cyc < q) tick();
    present_first();
    idx = 0;
    guard = 0;
    while (idx < fn && guard < 4000) begin
      @(negedge clk);
      hs = up_tx_req && up_tx_ready;
      tick();
      guard++;
      if (hs) idx++;
      if (idx < fn) begin
        up_tx_data = fb[idx];
        up_tx_last = (idx == fn - 1);
      end
    end
    if (idx < fn) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got %0d bits accepted, expected %0d", idx, fn);
    end
    up_tx_req = 1'b0;
    up_tx_data = 1'b0;
    up_tx_last = 1'b0;
  endtask

  // req_rel < 0: request held from rx_eoc; otherwise raised at r + req_rel.
  task automatic scenario(input bit lb, input int npause, input int eoc_gap, input int req_rel, input int nbits);
    longint r;
    longint q;
    longint t;
    bit tmo;
    fill_frame(nbits);
    pause_seq(npause, r);
    idle(eoc_gap);
    q = (req_rel < 0) ? cyc : r + req_rel;
    if (q < cyc) q = cyc;
    model(r, lb, q, tmo, t);
    if (tmo) begin
      push(K_TMO, t, 1'b0, 1'b0);
      eoc(lb, 1'b0);
      while (cyc < t + 5) tick();
    end else begin
      push_frame(t);
      if (req_rel < 0) present_first();
      eoc(lb, 1'b0);
      send_frame(q);
    end
    idle(4);
    chk("sb_drain", sb.size(), 0);
    chk("idle_after_frame", sched_active, 0);
  endtask

  initial begin
    longint r;
    longint t;
    bit tmo;
    int c0;
    checks = 0;
    failures = 0;
    ready_en = 1'b1;
    rst_n = 1'b0;
    pause_n_synchronised = 1'b1;
    rx_eoc = 1'b0;
    rx_error = 1'b0;
    rx_last_bit = 1'b0;
    up_tx_req = 1'b0;
    up_tx_data = 1'b0;
    up_tx_last = 1'b0;
    fn = 1;
    idle(4);
    chk("outputs_in_reset", {tx_req, tx_data, tx_last, up_tx_ready, fdt_timeout, sched_active}, 0);
    rst_n = 1'b1;
    idle(3);
    chk("outputs_after_reset", {tx_req, tx_data, tx_last, up_tx_ready, fdt_timeout, sched_active}, 0);

    scenario(1'b1, 1, 100, -1, 8);
    scenario(1'b0, 2, 80, -1, 8);
    scenario(1'b1, 1, 100, 1300, 8);

    scenario(1'b1, 1, 100, 5000, 8);
    c0 = txreq_cnt;
    fill_frame(4);
    present_first();
    idle(300);
    up_tx_req = 1'b0;
    chk("no_tx_after_timeout", txreq_cnt - c0, 0);

    // Abort by a new PCD frame, then FDT measured from the new last pause.
    fill_frame(8);
    pause_seq(1, r);
    present_first();
    eoc(1'b1, 1'b0);
    chk("active_counting", sched_active, 1);
    while (cyc < r + 499) tick();
    pause_n_synchronised = 1'b0;
    tick();
    chk("abort_to_idle", sched_active, 0);
    idle(10);
    pause_n_synchronised = 1'b1;
    r = cyc + 1;
    idle(60);
    model(r, 1'b1, cyc, tmo, t);
    chk("abort_model_slot", t - r, 1233);
    push_frame(t);
    eoc(1'b1, 1'b0);
    send_frame(cyc);
    idle(4);
    chk("sb_drain_abort", sb.size(), 0);

    // Errored frame: nothing scheduled.
    fill_frame(8);
    pause_seq(1, r);
    present_first();
    eoc(1'b1, 1'b1);
    chk("error_stays_idle", sched_active, 0);
    idle(2300);
    up_tx_req = 1'b0;
    chk("sb_drain_error", sb.size(), 0);

    // Reset while sending.
    ready_en = 1'b0;
    fill_frame(8);
    fb[0] = 1'b1;
    pause_seq(1, r);
    model(r, 1'b1, cyc, tmo, t);
    push(K_OFFER, t, 1'b0, 1'b0);
    present_first();
    eoc(1'b1, 1'b0);
    while (cyc < t + 3) tick();
    chk("tx_req_before_reset", {tx_req, tx_data}, 2'b11);
    chk("sb_offer_seen", sb.size(), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("outputs_reset_mid_send", {tx_req, tx_data, tx_last, up_tx_ready, fdt_timeout, sched_active}, 0);
    up_tx_req = 1'b0;
    up_tx_data = 1'b0;
    ready_en = 1'b1;
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 16; i++) begin
      scenario(1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(10, 150),
               ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 2200)),
               $urandom_range(1, 40));
    end

    chk("invariant_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
